// File: rtl/mini_cpu_core.sv
// Two-phase (fetch/execute) register-file CPU core with zero/carry flags,
// conditional branches, run/stall control and an absorbing HALT state.
module mini_cpu_core #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              refetch_q, refetch_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] res_q, res_d;
  logic              z_q, z_d, c_q, c_d;

  logic [3:0]        op, rd, rs1, rs2;
  logic [DATA_W-1:0] op_a, op_b, result;
  logic [DATA_W:0]   wide;
  logic              wr_en, flag_en, taken;

  assign op  = imem_data[15:12];
  assign rd  = imem_data[11:8];
  assign rs1 = imem_data[7:4];
  assign rs2 = imem_data[3:0];

  // Indices at or above NREGS match no entry, so they read as zero.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rs1 == 4'(i)) op_a = regs_q[i];
      if (rs2 == 4'(i)) op_b = regs_q[i];
    end
  end

  // wide[DATA_W] carries the carry/borrow/shifted-out bit; logic ops leave it 0.
  always_comb begin
    wide    = '0;
    wr_en   = 1'b0;
    flag_en = 1'b0;
    case (op)
      4'h1: begin wide = {1'b0, op_a} + {1'b0, op_b}; wr_en = 1'b1; flag_en = 1'b1; end
      4'h2: begin wide = {1'b0, DATA_W'(imem_data[7:0])}; wr_en = 1'b1; end
      4'h3: begin wide = {1'b0, op_a} - {1'b0, op_b}; wr_en = 1'b1; flag_en = 1'b1; end
      4'h4: begin wide = {1'b0, op_a & op_b}; wr_en = 1'b1; flag_en = 1'b1; end
      4'h5: begin wide = {1'b0, op_a | op_b}; wr_en = 1'b1; flag_en = 1'b1; end
      4'h6: begin wide = {1'b0, op_a ^ op_b}; wr_en = 1'b1; flag_en = 1'b1; end
      4'h7: begin wide = {op_a, 1'b0}; wr_en = 1'b1; flag_en = 1'b1; end
      default: ;
    endcase
  end

  assign result = wide[DATA_W-1:0];
  assign taken  = (op == 4'h8) || ((op == 4'h9) && z_q) || ((op == 4'hA) && c_q);

  always_comb begin
    state_d   = state_q;
    refetch_d = refetch_q;
    pc_d      = pc_q;
    regs_d    = regs_q;
    res_d     = res_q;
    z_d       = z_q;
    c_d       = c_q;
    if (run) begin
      case (state_q)
        S_FETCH: state_d = S_EXEC;
        S_EXEC: begin
          if (refetch_q) begin
            // Instruction word was lost during the stall; this cycle re-reads it.
            refetch_d = 1'b0;
          end else begin
            if (wr_en) begin
              res_d = result;
              for (int i = 0; i < NREGS; i++) begin
                if (rd == 4'(i)) regs_d[i] = result;
              end
            end
            if (flag_en) begin
              z_d = (result == '0);
              c_d = wide[DATA_W];
            end
            if (op == 4'hF) begin
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
              pc_d    = taken ? PC_W'(imem_data[7:0]) : pc_q + PC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end else if (state_q == S_EXEC) begin
      refetch_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      refetch_q <= 1'b0;
      pc_q      <= '0;
      res_q     <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      refetch_q <= refetch_d;
      pc_q      <= pc_d;
      res_q     <= res_d;
      z_q       <= z_d;
      c_q       <= c_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign imem_en    = reset_n && run &&
                      ((state_q == S_FETCH) || ((state_q == S_EXEC) && refetch_q));
  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign alu_result = res_q;
  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_mini_cpu_core.sv
// Directed bench for mini_cpu_core: two cores (wide PC / narrow PC with two
// registers) run hand-assembled programs against synchronous-read memories.
module tb_mini_cpu_core;

  logic        clk, reset_n, run;
  int          checks, failures;

  logic        a_en, a_z, a_c, a_halted;
  logic [7:0]  a_addr, a_pc;
  logic [15:0] a_data;
  logic [3:0]  a_alu;
  logic [15:0] mem_a [256];

  logic        b_en, b_z, b_c, b_halted;
  logic [3:0]  b_addr, b_pc;
  logic [15:0] b_data;
  logic [3:0]  b_alu;
  logic [15:0] mem_b [16];

  mini_cpu_core #(.DATA_W(4), .PC_W(8), .NREGS(4)) u_a (
    .clk(clk), .reset_n(reset_n), .run(run), .imem_en(a_en), .imem_addr(a_addr),
    .imem_data(a_data), .pc_out(a_pc), .alu_result(a_alu), .zero_flag(a_z),
    .carry_flag(a_c), .halted(a_halted)
  );

  mini_cpu_core #(.DATA_W(4), .PC_W(4), .NREGS(2)) u_b (
    .clk(clk), .reset_n(reset_n), .run(run), .imem_en(b_en), .imem_addr(b_addr),
    .imem_data(b_data), .pc_out(b_pc), .alu_result(b_alu), .zero_flag(b_z),
    .carry_flag(b_c), .halted(b_halted)
  );

  // Data is only valid after a strobe; otherwise the bus shows a HALT word.
  always_ff @(posedge clk) begin
    a_data <= a_en ? mem_a[a_addr] : 16'hF000;
    b_data <= b_en ? mem_b[b_addr] : 16'hF000;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem_b[i] = 16'h0000;
    mem_a[0]  = 16'h2004; mem_a[1]  = 16'h2101; mem_a[2]  = 16'h1201;
    mem_a[3]  = 16'h3321; mem_a[4]  = 16'h4231; mem_a[5]  = 16'h200F;
    mem_a[6]  = 16'h2101; mem_a[7]  = 16'h1201; mem_a[8]  = 16'h3210;
    mem_a[9]  = 16'h6301; mem_a[10] = 16'hA020; mem_a[11] = 16'h2000;
    mem_a[12] = 16'h3100; mem_a[13] = 16'h9010; mem_a[16] = 16'h7230;
    mem_a[17] = 16'h8030; mem_a[48] = 16'hF000;
    mem_b[1]  = 16'h9013; mem_b[2]  = 16'h8004; mem_b[3]  = 16'hF000;
    mem_b[4]  = 16'h2003; mem_b[5]  = 16'h2507; mem_b[6]  = 16'h5755;
    mem_b[7]  = 16'h5700; mem_b[8]  = 16'h2119; mem_b[9]  = 16'h5711;
    mem_b[10] = 16'h3711;

    reset_n = 1'b0;
    run     = 1'b1;
    #3;
    chk("rst_pc", 32'(a_pc), 32'h0);
    chk("rst_alu", 32'(a_alu), 32'h0);
    chk("rst_z", 32'(a_z), 32'h0);
    chk("rst_c", 32'(a_c), 32'h0);
    chk("rst_halted", 32'(a_halted), 32'h0);
    chk("rst_en", 32'(a_en), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("first_fetch_en", 32'(a_en), 32'h1);

    step(2); chk("a_ldi_r0", 32'(a_alu), 32'h4); chk("b_nop_pc", 32'(b_pc), 32'h1);
    step(2); chk("a_ldi_r1", 32'(a_alu), 32'h1); chk("b_bz_fall", 32'(b_pc), 32'h2);
    step(2); chk("a_add", 32'(a_alu), 32'h5); chk("b_jmp", 32'(b_pc), 32'h4);
    step(2); chk("a_sub", 32'(a_alu), 32'h4); chk("b_ldi_r0", 32'(b_alu), 32'h3);
    step(2); chk("a_and", 32'(a_alu), 32'h0); chk("a_and_z", 32'(a_z), 32'h1);
    chk("a_pc10", 32'(a_pc), 32'h5); chk("a_and_c", 32'(a_c), 32'h0);
    chk("b_ldi_r5", 32'(b_alu), 32'h7);
    step(2); chk("a_ldi_f", 32'(a_alu), 32'hF); chk("b_r5_reads0", 32'(b_alu), 32'h0);
    chk("b_r5_z", 32'(b_z), 32'h1);
    step(2); chk("a_ldi_1b", 32'(a_alu), 32'h1); chk("b_r0_kept", 32'(b_alu), 32'h3);
    step(2); chk("a_add_wrap", 32'(a_alu), 32'h0); chk("a_add_c", 32'(a_c), 32'h1);
    chk("a_add_z", 32'(a_z), 32'h1); chk("b_ldi_trunc", 32'(b_alu), 32'h9);
    step(2); chk("a_sub_borrow", 32'(a_alu), 32'h2); chk("a_borrow_c", 32'(a_c), 32'h1);
    chk("a_sub_z", 32'(a_z), 32'h0); chk("b_r1_kept", 32'(b_alu), 32'h9);
    step(2); chk("a_xor", 32'(a_alu), 32'hE); chk("a_xor_c", 32'(a_c), 32'h0);
    chk("b_sub0", 32'(b_alu), 32'h0); chk("b_sub_z", 32'(b_z), 32'h1);
    chk("b_sub_c", 32'(b_c), 32'h0);
    step(2); chk("a_bc_fall", 32'(a_pc), 32'hB); chk("a_bc_alu", 32'(a_alu), 32'hE);
    step(2); chk("a_ldi0", 32'(a_alu), 32'h0); chk("a_ldi_keep_z", 32'(a_z), 32'h0);
    step(2); chk("a_sub_self_z", 32'(a_z), 32'h1); chk("a_sub_self_c", 32'(a_c), 32'h0);
    step(2); chk("a_bz_pc", 32'(a_pc), 32'h10); chk("a_bz_en", 32'(a_en), 32'h1);
    chk("a_bz_addr", 32'(a_addr), 32'h10);
    step(2); chk("a_shl", 32'(a_alu), 32'hC); chk("a_shl_c", 32'(a_c), 32'h1);
    chk("a_shl_z", 32'(a_z), 32'h0); chk("b_pc_wrap", 32'(b_pc), 32'h0);
    step(2); chk("a_jmp", 32'(a_pc), 32'h30); chk("b_pc_after_wrap", 32'(b_pc), 32'h1);
    step(2); chk("a_halted", 32'(a_halted), 32'h1); chk("a_halt_pc", 32'(a_pc), 32'h30);
    chk("a_halt_en", 32'(a_en), 32'h0); chk("b_bz_trunc", 32'(b_pc), 32'h3);
    step(2); chk("b_halted", 32'(b_halted), 32'h1); chk("b_halt_pc", 32'(b_pc), 32'h3);
    chk("b_halt_en", 32'(b_en), 32'h0); chk("b_halt_alu", 32'(b_alu), 32'h0);
    step(20);
    chk("a_halt_hold", 32'(a_halted), 32'h1); chk("a_halt_pc_hold", 32'(a_pc), 32'h30);
    chk("a_halt_en_hold", 32'(a_en), 32'h0); chk("b_halt_hold", 32'(b_halted), 32'h1);
    chk("b_halt_pc_hold", 32'(b_pc), 32'h3); chk("b_halt_en_hold", 32'(b_en), 32'h0);

    // Asynchronous reset out of HALT, then a randomly stalled rerun.
    #2 reset_n = 1'b0;
    #1 chk("ar_halted_a", 32'(a_halted), 32'h0); chk("ar_halted_b", 32'(b_halted), 32'h0);
    chk("ar_pc", 32'(a_pc), 32'h0); chk("ar_alu", 32'(a_alu), 32'h0);
    chk("ar_c", 32'(a_c), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 1000 && !(a_halted && b_halted); i++) begin
      run = 1'($urandom_range(0, 1));
      step(1);
    end
    run = 1'b1;
    chk("stall_a_halted", 32'(a_halted), 32'h1); chk("stall_b_halted", 32'(b_halted), 32'h1);
    chk("stall_a_alu", 32'(a_alu), 32'hC); chk("stall_a_c", 32'(a_c), 32'h1);
    chk("stall_a_pc", 32'(a_pc), 32'h30); chk("stall_b_alu", 32'(b_alu), 32'h0);
    chk("stall_b_pc", 32'(b_pc), 32'h3); chk("stall_b_z", 32'(b_z), 32'h1);

    // EXEC stall of 3 cycles forces a re-fetch, then reset lands mid-EXEC.
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    run = 1'b0;
    step(3);
    chk("xs_en", 32'(a_en), 32'h0); chk("xs_alu", 32'(a_alu), 32'h0);
    chk("xs_pc", 32'(a_pc), 32'h0);
    run = 1'b1;
    #1 chk("xs_refetch_en", 32'(a_en), 32'h1);
    step(2); chk("xs_alu_done", 32'(a_alu), 32'h4); chk("xs_pc_done", 32'(a_pc), 32'h1);
    step(3); chk("mid_alu", 32'(a_alu), 32'h1); chk("mid_pc", 32'(a_pc), 32'h2);
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_pc", 32'(a_pc), 32'h0); chk("mid_rst_alu", 32'(a_alu), 32'h0);
    chk("mid_rst_halted", 32'(a_halted), 32'h0); chk("mid_rst_en", 32'(a_en), 32'h0);
    chk("mid_rst_z", 32'(a_z), 32'h0);
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
